// File: rtl/adder_scoreboard_if.sv
// Transaction and status bundle between the adder monitor side and adder_scoreboard.
interface adder_scoreboard_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic                       in_valid;
  logic [WIDTH-1:0]           a;
  logic [WIDTH-1:0]           b;
  logic                       out_valid;
  logic [WIDTH:0]             c;
  logic [CNT_W-1:0]           pass_cnt;
  logic [CNT_W-1:0]           fail_cnt;
  logic                       mismatch;
  logic                       overflow;
  logic                       underflow;
  logic                       timeout;
  logic [$clog2(DEPTH):0]     pending;
  logic [WIDTH:0]             last_exp;
  logic [WIDTH:0]             last_got;
  logic                       busy;

  modport master (
    output in_valid, a, b, out_valid, c,
    input  pass_cnt, fail_cnt, mismatch, overflow, underflow, timeout,
    input  pending, last_exp, last_got, busy
  );

  modport slave (
    input  in_valid, a, b, out_valid, c,
    output pass_cnt, fail_cnt, mismatch, overflow, underflow, timeout,
    output pending, last_exp, last_got, busy
  );
endinterface

// File: rtl/adder_scoreboard.sv
// In-order scoreboard for an adder: predicts a+b per transaction, compares results against a FIFO.
// Define SB_TIMEOUT_EN to discard head entries that wait MAX_LAT cycles without a result.
module adder_scoreboard #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_LAT = 15
) (
  input logic              clk,
  input logic              rst,
  adder_scoreboard_if.slave sb
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic             mismatch_q, overflow_q, overflow_d, underflow_q, underflow_d;
  logic             timeout_q, timeout_d;
  logic [WIDTH:0]   last_exp_q, last_got_q;
  state_e           state_q, state_d;

  logic             empty, full, pop, drop, push, match, to_ev;
  logic [WIDTH:0]   exp_sum, head;

`ifdef SB_TIMEOUT_EN
  localparam int unsigned AgeW = $clog2(MAX_LAT + 1);
  logic [AgeW-1:0]  age_q, age_d;
`endif

  assign head    = mem_q[rd_ptr_q];
  assign exp_sum = {1'b0, sb.a} + {1'b0, sb.b};

  always_comb begin
    empty = (cnt_q == '0);
    full  = (cnt_q == OccW'(DEPTH));
    pop   = sb.out_valid && !empty;
    match = (sb.c == head);
`ifdef SB_TIMEOUT_EN
    // A result landing on the expiry edge wins over the timeout.
    to_ev = !empty && !pop && (age_q == AgeW'(MAX_LAT - 1));
    age_d = (empty || pop || to_ev) ? '0 : age_q + AgeW'(1);
`else
    to_ev = 1'b0;
`endif
    drop        = pop || to_ev;
    push        = sb.in_valid && (!full || drop);
    cnt_d       = cnt_q + OccW'(push) - OccW'(drop);
    overflow_d  = overflow_q || (sb.in_valid && full && !drop);
    underflow_d = underflow_q || (sb.out_valid && empty);
    timeout_d   = timeout_q || to_ev;
    pass_d      = pass_q;
    fail_d      = fail_q;
    if (pop && match && (pass_q != '1)) pass_d = pass_q + CNT_W'(1);
    if (((pop && !match) || to_ev) && (fail_q != '1)) fail_d = fail_q + CNT_W'(1);
    if (overflow_d || underflow_d || timeout_d) state_d = StErr;
    else if (cnt_d != '0)                         state_d = StBusy;
    else                                          state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      timeout_q   <= 1'b0;
      last_exp_q  <= '0;
      last_got_q  <= '0;
      state_q     <= StIdle;
`ifdef SB_TIMEOUT_EN
      age_q       <= '0;
`endif
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= exp_sum;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (drop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (pop) begin
        last_exp_q <= head;
        last_got_q <= sb.c;
      end
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      mismatch_q  <= pop && !match;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      timeout_q   <= timeout_d;
      state_q     <= state_d;
`ifdef SB_TIMEOUT_EN
      age_q       <= age_d;
`endif
    end
  end

  assign sb.pass_cnt  = pass_q;
  assign sb.fail_cnt  = fail_q;
  assign sb.mismatch  = mismatch_q;
  assign sb.overflow  = overflow_q;
  assign sb.underflow = underflow_q;
  assign sb.timeout   = timeout_q;
  assign sb.pending   = cnt_q;
  assign sb.last_exp  = last_exp_q;
  assign sb.last_got  = last_got_q;
  assign sb.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_adder_scoreboard.sv
// Self-checking bench for adder_scoreboard: vector table, directed corner sequences, random run.
module tb_adder_scoreboard;
  localparam int WIDTH   = 4;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;
  localparam int MAX_LAT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  adder_scoreboard_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) sb_if ();

  adder_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_LAT(MAX_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  // Reference model state
  int q[$];
  int m_pass, m_fail, m_last_exp, m_last_got, m_age;
  bit m_mism, m_over, m_under, m_to;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_pass = 0; m_fail = 0; m_last_exp = 0; m_last_got = 0; m_age = 0;
    m_mism = 0; m_over = 0; m_under = 0; m_to = 0;
  endtask

  task automatic model_step(input bit iv, input int a, input int b, input bit ov, input int c);
    int  sat;
    bit  pre_empty, popd, to, removed;
    int  pre_size, head;
    sat       = (1 << CNT_W) - 1;
    pre_size  = q.size();
    pre_empty = (pre_size == 0);
    popd      = ov && !pre_empty;
    to        = 1'b0;
    m_mism    = 1'b0;
    if (ov && pre_empty) m_under = 1'b1;
`ifdef SB_TIMEOUT_EN
    // Head has already waited m_age cycles; this idle edge makes MAX_LAT.
    if (!pre_empty && !popd && (m_age + 1 == MAX_LAT)) to = 1'b1;
`endif
    if (popd) begin
      head = q.pop_front();
      m_last_exp = head;
      m_last_got = c;
      if (c == head) begin
        if (m_pass < sat) m_pass++;
      end else begin
        if (m_fail < sat) m_fail++;
        m_mism = 1'b1;
      end
    end
    if (to) begin
      void'(q.pop_front());
      if (m_fail < sat) m_fail++;
      m_to = 1'b1;
    end
    removed = popd || to;
    if (iv) begin
      if (pre_size == DEPTH && !removed) m_over = 1'b1;
      else q.push_back(a + b);
    end
    if (pre_empty || removed) m_age = 0;
    else m_age++;
  endtask

  task automatic check_all();
    bit m_busy;
    m_busy = m_over || m_under || m_to || (q.size() > 0);
    chk("pass_cnt",  32'(sb_if.pass_cnt),  32'(m_pass));
    chk("fail_cnt",  32'(sb_if.fail_cnt),  32'(m_fail));
    chk("mismatch",  32'(sb_if.mismatch),  32'(m_mism));
    chk("overflow",  32'(sb_if.overflow),  32'(m_over));
    chk("underflow", 32'(sb_if.underflow), 32'(m_under));
    chk("timeout",   32'(sb_if.timeout),   32'(m_to));
    chk("pending",   32'(sb_if.pending),   32'(q.size()));
    chk("last_exp",  32'(sb_if.last_exp),  32'(m_last_exp));
    chk("last_got",  32'(sb_if.last_got),  32'(m_last_got));
    chk("busy",      32'(sb_if.busy),      32'(m_busy));
  endtask

  task automatic cyc(input bit iv, input int a, input int b, input bit ov, input int c);
    int aa, bb, cc;
    aa = a & ((1 << WIDTH) - 1);
    bb = b & ((1 << WIDTH) - 1);
    cc = c & ((1 << (WIDTH + 1)) - 1);
    sb_if.in_valid  = iv;
    sb_if.a         = aa[WIDTH-1:0];
    sb_if.b         = bb[WIDTH-1:0];
    sb_if.out_valid = ov;
    sb_if.c         = cc[WIDTH:0];
    model_step(iv, aa, bb, ov, cc);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0, 0);
  endtask

  // Asynchronous: outputs must clear without waiting for an edge.
  task automatic do_reset();
    sb_if.in_valid  = 1'b0;
    sb_if.out_valid = 1'b0;
    sb_if.a         = '0;
    sb_if.b         = '0;
    sb_if.c         = '0;
    rst = 1'b1;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int a;
    int b;
    int c;
    int exp_sum;
    bit exp_fail;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int e_pass, e_fail;
    sb_if.in_valid  = 1'b0;
    sb_if.out_valid = 1'b0;
    sb_if.a         = '0;
    sb_if.b         = '0;
    sb_if.c         = '0;
    model_clear();

    tbl[0] = '{a: 3,  b: 4,  c: 7,  exp_sum: 7,  exp_fail: 1'b0};
    tbl[1] = '{a: 15, b: 15, c: 29, exp_sum: 30, exp_fail: 1'b1};
    tbl[2] = '{a: 0,  b: 0,  c: 0,  exp_sum: 0,  exp_fail: 1'b0};
    tbl[3] = '{a: 15, b: 0,  c: 15, exp_sum: 15, exp_fail: 1'b0};
    tbl[4] = '{a: 9,  b: 8,  c: 17, exp_sum: 17, exp_fail: 1'b0};
    tbl[5] = '{a: 7,  b: 7,  c: 13, exp_sum: 14, exp_fail: 1'b1};

    // Reset state and single-transaction vectors
    #2;
    do_reset();
    chk("rst_busy", 32'(sb_if.busy), 32'd0);
    e_pass = 0;
    e_fail = 0;
    foreach (tbl[i]) begin
      cyc(1'b1, tbl[i].a, tbl[i].b, 1'b0, 0);
      chk("vec_pending_after_push", 32'(sb_if.pending), 32'd1);
      cyc(1'b0, 0, 0, 1'b0, 0);
      cyc(1'b0, 0, 0, 1'b1, tbl[i].c);
      if (tbl[i].exp_fail) e_fail++;
      else e_pass++;
      chk("vec_last_exp", 32'(sb_if.last_exp), 32'(tbl[i].exp_sum));
      chk("vec_last_got", 32'(sb_if.last_got), 32'(tbl[i].c));
      chk("vec_mismatch", 32'(sb_if.mismatch), 32'(tbl[i].exp_fail));
      chk("vec_pass",     32'(sb_if.pass_cnt), 32'(e_pass));
      chk("vec_fail",     32'(sb_if.fail_cnt), 32'(e_fail));
      chk("vec_pending",  32'(sb_if.pending),  32'd0);
      cyc(1'b0, 0, 0, 1'b0, 0);
      chk("vec_mismatch_one_cycle", 32'(sb_if.mismatch), 32'd0);
      chk("vec_busy_idle",          32'(sb_if.busy),     32'd0);
    end

    // Fill, then push+pop while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, i, i, 1'b0, 0);
    chk("full_pending", 32'(sb_if.pending), 32'd8);
    cyc(1'b1, 5, 5, 1'b1, 0);
    chk("full_pushpop_overflow", 32'(sb_if.overflow), 32'd0);
    chk("full_pushpop_pending",  32'(sb_if.pending),  32'd8);
    chk("full_pushpop_pass",     32'(sb_if.pass_cnt), 32'd1);

    // Overflow then drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, i, i, 1'b0, 0);
    cyc(1'b1, 1, 1, 1'b0, 0);
    chk("ovf_flag",    32'(sb_if.overflow), 32'd1);
    chk("ovf_pending", 32'(sb_if.pending),  32'd8);
    chk("ovf_busy",    32'(sb_if.busy),     32'd1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 0, 0, 1'b1, 2 * i);
    chk("drain_pass",    32'(sb_if.pass_cnt), 32'd8);
    chk("drain_pending", 32'(sb_if.pending),  32'd0);
    chk("err_sticky_busy", 32'(sb_if.busy),   32'd1);

    // Empty compare
    do_reset();
    cyc(1'b0, 0, 0, 1'b1, 3);
    chk("unf_flag", 32'(sb_if.underflow), 32'd1);
    chk("unf_pass", 32'(sb_if.pass_cnt),  32'd0);
    chk("unf_fail", 32'(sb_if.fail_cnt),  32'd0);
    cyc(1'b1, 2, 3, 1'b1, 5);
    chk("unf_same_cycle_push", 32'(sb_if.pending), 32'd1);

    // Head ageing
    do_reset();
    cyc(1'b1, 1, 1, 1'b0, 0);
`ifdef SB_TIMEOUT_EN
    idle(MAX_LAT - 1);
    chk("to_not_yet", 32'(sb_if.timeout), 32'd0);
    idle(1);
    chk("to_flag",    32'(sb_if.timeout),  32'd1);
    chk("to_fail",    32'(sb_if.fail_cnt), 32'd1);
    chk("to_pending", 32'(sb_if.pending),  32'd0);
`else
    idle(MAX_LAT + 5);
    chk("noto_pending", 32'(sb_if.pending), 32'd1);
    chk("noto_flag",    32'(sb_if.timeout), 32'd0);
`endif

    // Mid-stream reset with pending=5 and overflow set
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, i, 1, 1'b0, 0);
    cyc(1'b1, 1, 1, 1'b0, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 0, 1'b1, i + 1);
    chk("pre_rst_pending", 32'(sb_if.pending), 32'd5);
    do_reset();
    chk("rst_pending",  32'(sb_if.pending),  32'd0);
    chk("rst_overflow", 32'(sb_if.overflow), 32'd0);
    chk("rst_busy2",    32'(sb_if.busy),     32'd0);
    cyc(1'b1, 2, 2, 1'b0, 0);
    cyc(1'b0, 0, 0, 1'b0, 0);
    cyc(1'b0, 0, 0, 1'b1, 4);
    chk("post_rst_pass", 32'(sb_if.pass_cnt), 32'd1);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit iv, ov;
      int c;
      iv = ($urandom_range(0, 2) != 0);
      ov = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      if (q.size() > 0 && $urandom_range(0, 5) != 0) c = q[0];
      else c = int'($urandom_range(0, 31));
      cyc(iv, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), ov, c);
      if (n % 150 == 149) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
